// File: rtl/finite_state_pkg.sv
// Shared types and constants for the keypad vending-machine controller.
// Key codes are {row_idx, col_idx} of the single low row/column line.
package finite_state_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL_PRODUCT,
        SEL_QTY,
        CONFIRM,
        PAYMENT,
        DISPENSE
    } state_t;

    localparam logic [3:0] KEY_START    = 4'hF;  // r3c3
    localparam logic [3:0] KEY_CANCEL   = 4'hC;  // r3c0
    localparam logic [3:0] KEY_QTY_INC  = 4'h5;  // r1c1
    localparam logic [3:0] KEY_QTY_OK   = 4'h9;  // r2c1
    localparam logic [3:0] KEY_PRICE_OK = 4'hD;  // r3c1
    localparam logic [1:0] COIN_COL     = 2'd2;

    localparam logic [7:0] COIN_R0 = 8'd1;
    localparam logic [7:0] COIN_R1 = 8'd2;
    localparam logic [7:0] COIN_R2 = 8'd5;
    localparam logic [7:0] COIN_R3 = 8'd10;

    // True only for exactly one low bit; X or multiple lows fall to default.
    function automatic logic low_onehot(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: low_onehot = 1'b1;
            default:                            low_onehot = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        case (v)
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] coin_value(input logic [1:0] row);
        case (row)
            2'd0:    coin_value = COIN_R0;
            2'd1:    coin_value = COIN_R1;
            2'd2:    coin_value = COIN_R2;
            default: coin_value = COIN_R3;
        endcase
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Samples the active-low keypad lines into a registered key code and emits a
// one-cycle press pulse when a valid code differs from the previous sample.
module keypad_decoder
    import finite_state_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] c,
    input  logic [3:0] r,
    output logic [3:0] key,
    output logic       press
);

    logic       dec_valid;
    logic [3:0] dec_code;
    logic       valid_q;
    logic [3:0] code_q;

    always_comb begin
        dec_valid = 1'b0;
        dec_code  = 4'h0;
        if (low_onehot(c) && low_onehot(r)) begin
            dec_valid = 1'b1;
            dec_code  = {low_idx(r), low_idx(c)};
        end
    end

    // History compares valid flag too, so NONE -> key always counts as new.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            code_q  <= 4'h0;
            press   <= 1'b0;
        end else begin
            press   <= dec_valid && (!valid_q || dec_code != code_q);
            valid_q <= dec_valid;
            code_q  <= dec_code;
        end
    end

    assign key = code_q;

endmodule

// File: rtl/finite_state.sv
// Vending-machine controller: keypad press events drive the purchase FSM and
// the registered price / quantity / total / paid-amount display values.
module finite_state
    import finite_state_pkg::*;
#(
    parameter logic [7:0] PRICE0  = 8'd10,
    parameter logic [7:0] PRICE1  = 8'd15,
    parameter logic [7:0] PRICE2  = 8'd20,
    parameter logic [7:0] PRICE3  = 8'd25,
    parameter logic [7:0] QTY_MAX = 8'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] c,
    input  logic [3:0] r,
    output logic [7:0] view_price,
    output logic [7:0] view_quantity,
    output logic [7:0] view_price_q,
    output logic [7:0] entered_amount
);

    logic [3:0] key;
    logic       press;
    state_t     state, state_n;
    logic [7:0] price_n, qty_n, pq_n, amount_n;
    logic [8:0] sum;

    keypad_decoder u_keypad (
        .clk   (clk),
        .reset (reset),
        .c     (c),
        .r     (r),
        .key   (key),
        .press (press)
    );

    function automatic logic [7:0] price_of(input logic [1:0] k);
        case (k)
            2'd0:    price_of = PRICE0;
            2'd1:    price_of = PRICE1;
            2'd2:    price_of = PRICE2;
            default: price_of = PRICE3;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            view_price     <= 8'd0;
            view_quantity  <= 8'd0;
            view_price_q   <= 8'd0;
            entered_amount <= 8'd0;
        end else begin
            state          <= state_n;
            view_price     <= price_n;
            view_quantity  <= qty_n;
            view_price_q   <= pq_n;
            entered_amount <= amount_n;
        end
    end

    always_comb begin
        state_n  = state;
        price_n  = view_price;
        qty_n    = view_quantity;
        amount_n = entered_amount;
        sum      = {1'b0, entered_amount} + {1'b0, coin_value(key[3:2])};
        if (press) begin
            if (key == KEY_CANCEL && state != IDLE) begin
                state_n  = IDLE;
                price_n  = 8'd0;
                qty_n    = 8'd0;
                amount_n = 8'd0;
            end else begin
                case (state)
                    IDLE:
                        if (key == KEY_START) state_n = SEL_PRODUCT;
                    SEL_PRODUCT:
                        if (key[3:2] == 2'd0) begin
                            price_n = price_of(key[1:0]);
                            qty_n   = 8'd0;
                            state_n = SEL_QTY;
                        end
                    SEL_QTY:
                        if (key == KEY_QTY_INC) begin
                            if (view_quantity < QTY_MAX) qty_n = view_quantity + 8'd1;
                        end else if (key == KEY_QTY_OK && view_quantity != 8'd0) begin
                            state_n = CONFIRM;
                        end
                    CONFIRM:
                        if (key == KEY_PRICE_OK) begin
                            amount_n = 8'd0;
                            state_n  = PAYMENT;
                        end
                    PAYMENT:
                        if (key[1:0] == COIN_COL) begin
                            amount_n = sum[8] ? 8'hFF : sum[7:0];
                            if (amount_n >= view_price_q) state_n = DISPENSE;
                        end
                    DISPENSE:
                        if (key == KEY_START) begin
                            price_n  = 8'd0;
                            qty_n    = 8'd0;
                            amount_n = 8'd0;
                            state_n  = SEL_PRODUCT;
                        end
                    default: state_n = IDLE;
                endcase
            end
        end
        // Total tracks the next price/quantity so it lands in the same cycle.
        pq_n = price_n * qty_n;
    end

endmodule

// File: tb/tb_finite_state.sv
// Directed walk through the purchase flow plus randomized keypad traffic,
// compared against a press-level behavioural model of the vending machine.
module tb_finite_state;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] c, r;
    logic [7:0] view_price, view_quantity, view_price_q, entered_amount;

    int n_tests = 0;
    int n_fail  = 0;

    finite_state dut (
        .clk            (clk),
        .reset          (reset),
        .c              (c),
        .r              (r),
        .view_price     (view_price),
        .view_quantity  (view_quantity),
        .view_price_q   (view_price_q),
        .entered_amount (entered_amount)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_SELP = 1, M_SELQ = 2, M_CONF = 3, M_PAY = 4, M_DISP = 5;
    int prices[4] = '{10, 15, 20, 25};
    int coins[4]  = '{1, 2, 5, 10};
    int m_st, m_price, m_qty, m_amt, m_prev;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_st = M_IDLE; m_price = 0; m_qty = 0; m_amt = 0; m_prev = -1;
    endtask

    function automatic int low_pos(input logic [3:0] v);
        int n = 0, p = -1;
        for (int i = 0; i < 4; i++)
            if (v[i] === 1'b0) begin n++; p = i; end
        return (n == 1) ? p : -1;
    endfunction

    task automatic m_apply(input int k);
        if (k == 12 && m_st != M_IDLE) begin
            m_st = M_IDLE; m_price = 0; m_qty = 0; m_amt = 0;
        end else begin
            case (m_st)
                M_IDLE: if (k == 15) m_st = M_SELP;
                M_SELP: if (k < 4) begin m_price = prices[k]; m_qty = 0; m_st = M_SELQ; end
                M_SELQ: begin
                    if (k == 5) begin if (m_qty < 9) m_qty++; end
                    else if (k == 9 && m_qty >= 1) m_st = M_CONF;
                end
                M_CONF: if (k == 13) begin m_amt = 0; m_st = M_PAY; end
                M_PAY: if (k % 4 == 2) begin
                    m_amt = m_amt + coins[k / 4];
                    if (m_amt > 255) m_amt = 255;
                    if (m_amt >= m_price * m_qty) m_st = M_DISP;
                end
                M_DISP: if (k == 15) begin m_price = 0; m_qty = 0; m_amt = 0; m_st = M_SELP; end
                default: ;
            endcase
        end
    endtask

    task automatic m_step(input logic [3:0] cv, input logic [3:0] rv);
        int ci = low_pos(cv), ri = low_pos(rv);
        int cur = (ci >= 0 && ri >= 0) ? ri * 4 + ci : -1;
        if (cur >= 0 && cur != m_prev) m_apply(cur);
        m_prev = cur;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] cv, input logic [3:0] rv);
        @(negedge clk);
        c = cv; r = rv;
        m_step(cv, rv);
    endtask

    task automatic press(input int row, input int col, input int hold, input int gap);
        logic [3:0] one = 4'b0001;
        for (int i = 0; i < hold; i++) drive(~(one << col), ~(one << row));
        for (int i = 0; i < gap; i++) drive(4'hF, 4'hF);
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        chk({tag, ".price"}, view_price, m_price);
        chk({tag, ".qty"},   view_quantity, m_qty);
        chk({tag, ".pq"},    view_price_q, m_price * m_qty);
        chk({tag, ".amt"},   entered_amount, m_amt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".price"}, view_price, 0);
        chk({tag, ".qty"},   view_quantity, 0);
        chk({tag, ".pq"},    view_price_q, 0);
        chk({tag, ".amt"},   entered_amount, 0);
    endtask

    initial begin
        int row, col, pick;
        int keys[10] = '{15, 12, 0, 1, 2, 3, 5, 9, 13, 14};

        // Reset with undriven keypad
        reset = 1'b0; c = 'x; r = 'x;
        m_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        c = 4'hF; r = 4'hF; reset = 1'b1;
        repeat (3) @(posedge clk);
        check_all("rst_rel");
        check_zero("rst_rel0");

        // START, product 0 with latency probe, held QTY_INC
        press(3, 3, 2, 1);
        @(negedge clk);
        c = 4'b1110; r = 4'b1110;
        m_step(c, r);
        @(posedge clk); #1;
        chk("lat_pre", view_price, 0);
        @(posedge clk); #1;
        chk("lat_post", view_price, 10);
        drive(4'b1110, 4'b1110);
        press(1, 1, 10, 1);
        check_all("hold");
        chk("hold_qty", view_quantity, 1);
        chk("hold_pq", view_price_q, 10);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        m_reset();
        @(negedge clk);
        reset = 1'b1;

        // Quantity saturation on product 3
        press(3, 3, 1, 1);
        press(0, 3, 1, 1);
        for (int i = 0; i < 12; i++) press(1, 1, 1, 1);
        check_all("sat");
        chk("sat_qty", view_quantity, 9);
        chk("sat_pq", view_price_q, 225);

        // Full purchase: product 1, qty 2, pay 30
        press(3, 0, 1, 1);
        press(3, 3, 1, 1);
        press(0, 1, 1, 1);
        press(1, 1, 1, 1);
        press(1, 1, 1, 1);
        press(2, 1, 1, 1);
        press(3, 1, 1, 1);
        press(3, 2, 1, 1); check_all("coin1"); chk("coin1_amt", entered_amount, 10);
        press(3, 2, 1, 1); check_all("coin2"); chk("coin2_amt", entered_amount, 20);
        press(3, 2, 1, 1); check_all("coin3"); chk("coin3_amt", entered_amount, 30);
        press(3, 2, 1, 1); check_all("disp");  chk("disp_amt", entered_amount, 30);

        // Guarding: coin in SEL_PRODUCT, QTY_OK at qty 0, invalid double-low
        press(3, 0, 1, 1);
        press(3, 3, 1, 1);
        press(3, 2, 1, 1); check_all("g_coin"); chk("g_coin_amt", entered_amount, 0);
        press(0, 0, 1, 1);
        press(2, 1, 1, 1);
        press(1, 1, 1, 1); check_all("g_qok0"); chk("g_qok0_qty", view_quantity, 1);
        drive(4'b1100, 4'b1110);
        drive(4'hF, 4'hF);
        check_all("g_inv");

        // Cancel mid-payment, then restart
        press(2, 1, 1, 1);
        press(3, 1, 1, 1);
        press(2, 2, 1, 1); check_all("c_pay"); chk("c_pay_amt", entered_amount, 5);
        press(3, 0, 1, 1); check_all("cancel"); check_zero("cancel0");
        press(3, 3, 1, 1);
        press(0, 2, 1, 1); check_all("restart"); chk("restart_price", view_price, 20);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 19);
            if (pick == 0) begin
                @(negedge clk);
                reset = 1'b0;
                m_reset();
                @(negedge clk);
                reset = 1'b1;
            end else if (pick < 3) begin
                drive(4'($urandom), 4'($urandom));
                drive(4'hF, 4'hF);
            end else begin
                row = keys[$urandom_range(0, 9)];
                col = row % 4;
                row = row / 4;
                press(row, col, $urandom_range(1, 4), $urandom_range(1, 3));
            end
            check_all($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
